// File: rtl/dram_access_arbiter_if.sv
// dram_access_arbiter_if
//   Bundles the DRAM port arbitration signals shared between the requesters /
//   DRAM controller side (master) and the arbiter itself (slave).
//   Requests and DramDone_H flow into the arbiter; grants, the start pulse,
//   refresh bookkeeping and the watchdog pulse flow out of it.
//     CpuReq_H        CPU DRAM request (select qualified with address strobe)
//     DmaReq_H        DMA DRAM request
//     DramDone_H      one-cycle end-of-access pulse from the DRAM controller
//     CpuGrant_H      CPU owns the DRAM port
//     DmaGrant_H      DMA owns the DRAM port
//     RefreshReq_H    refresh cycle in progress
//     DramStart_H     one-cycle pulse on the first cycle of every grant
//     RefreshPending  outstanding refresh count, saturating at 3
//     Overrun_H       sticky refresh overrun flag
//     Timeout_H       one-cycle pulse when the watchdog forces a release
interface dram_access_arbiter_if;
    logic       CpuReq_H;
    logic       DmaReq_H;
    logic       DramDone_H;
    logic       CpuGrant_H;
    logic       DmaGrant_H;
    logic       RefreshReq_H;
    logic       DramStart_H;
    logic [1:0] RefreshPending;
    logic       Overrun_H;
    logic       Timeout_H;

    modport master (
        output CpuReq_H, DmaReq_H, DramDone_H,
        input  CpuGrant_H, DmaGrant_H, RefreshReq_H, DramStart_H,
        input  RefreshPending, Overrun_H, Timeout_H
    );

    modport slave (
        input  CpuReq_H, DmaReq_H, DramDone_H,
        output CpuGrant_H, DmaGrant_H, RefreshReq_H, DramStart_H,
        output RefreshPending, Overrun_H, Timeout_H
    );
endinterface

// File: rtl/dram_access_arbiter.sv
// dram_access_arbiter
//   Shares the single DRAM controller port between the CPU, the DMA engine
//   and periodic refresh. One owner at a time; every grant opens with a
//   DramStart_H pulse and closes on DramDone_H or on the watchdog.
//   Ports:
//     Clock    system clock, rising edge
//     Reset_L  asynchronous active-low reset
//     bus      dram_access_arbiter_if.slave (requests in, grants/status out)
//   Parameters:
//     REFRESH_INTERVAL  cycles between refresh ticks
//     TIMEOUT           cycles a grant may stay open without DramDone_H
module dram_access_arbiter #(
    parameter int REFRESH_INTERVAL = 375,
    parameter int TIMEOUT          = 255
) (
    input  logic                  Clock,
    input  logic                  Reset_L,
    dram_access_arbiter_if.slave  bus
);

    // Timer only ever holds 0..REFRESH_INTERVAL-1; the watchdog must be
    // able to represent TIMEOUT-1 and its successor comparison.
    localparam int TIMER_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam int WDOG_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(REFRESH_INTERVAL - 1);
    localparam logic [WDOG_W-1:0]  WDOG_LAST    = WDOG_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CPU     = 2'd1,
        ST_DMA     = 2'd2,
        ST_REFRESH = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [WDOG_W-1:0]    wdog_q, wdog_d;
    logic [1:0]           pending_q, pending_d;
    logic                 overrun_q, overrun_d;
    logic                 last_dma_q, last_dma_d;
    logic                 cpu_grant_q, cpu_grant_d;
    logic                 dma_grant_q, dma_grant_d;
    logic                 refresh_req_q, refresh_req_d;
    logic                 start_q, start_d;
    logic                 timeout_q, timeout_d;

    logic                 tick;
    logic                 refresh_done;

    // Refresh timer and debt counter
    always_comb begin
        tick         = (timer_q == '0);
        refresh_done = (state_q == ST_REFRESH) && bus.DramDone_H;
        timer_d      = tick ? TIMER_RELOAD : (timer_q - 1'b1);
        pending_d    = pending_q;
        // A tick and a completed refresh in the same cycle cancel out.
        if (tick && !refresh_done) begin
            if (pending_q != 2'd3) begin
                pending_d = pending_q + 2'd1;
            end
        end else if (!tick && refresh_done) begin
            if (pending_q != 2'd0) begin
                pending_d = pending_q - 2'd1;
            end
        end
        overrun_d = overrun_q | (tick && (pending_q == 2'd3));
    end

    // Arbitration FSM: next state and registered-output values
    always_comb begin
        state_d    = state_q;
        last_dma_d = last_dma_q;
        wdog_d     = wdog_q;
        start_d    = 1'b0;
        timeout_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                wdog_d = '0;
                if (pending_q >= 2'd2) begin
                    state_d = ST_REFRESH;
                end else if (bus.CpuReq_H && bus.DmaReq_H) begin
                    state_d = last_dma_q ? ST_CPU : ST_DMA;
                end else if (bus.CpuReq_H) begin
                    state_d = ST_CPU;
                end else if (bus.DmaReq_H) begin
                    state_d = ST_DMA;
                end else if (pending_q == 2'd1) begin
                    state_d = ST_REFRESH;
                end

                if (state_d != ST_IDLE) begin
                    start_d = 1'b1;
                end
                // Refresh grants leave the round-robin history alone.
                if (state_d == ST_CPU) begin
                    last_dma_d = 1'b0;
                end else if (state_d == ST_DMA) begin
                    last_dma_d = 1'b1;
                end
            end

            ST_CPU, ST_DMA, ST_REFRESH: begin
                // Requests dropping mid-grant are deliberately ignored.
                if (bus.DramDone_H) begin
                    state_d = ST_IDLE;
                end else if (wdog_q == WDOG_LAST) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cpu_grant_d   = (state_d == ST_CPU);
        dma_grant_d   = (state_d == ST_DMA);
        refresh_req_d = (state_d == ST_REFRESH);
    end

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q       <= ST_IDLE;
            timer_q       <= TIMER_RELOAD;
            wdog_q        <= '0;
            pending_q     <= 2'd0;
            overrun_q     <= 1'b0;
            last_dma_q    <= 1'b0;
            cpu_grant_q   <= 1'b0;
            dma_grant_q   <= 1'b0;
            refresh_req_q <= 1'b0;
            start_q       <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            wdog_q        <= wdog_d;
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
            last_dma_q    <= last_dma_d;
            cpu_grant_q   <= cpu_grant_d;
            dma_grant_q   <= dma_grant_d;
            refresh_req_q <= refresh_req_d;
            start_q       <= start_d;
            timeout_q     <= timeout_d;
        end
    end

    assign bus.CpuGrant_H     = cpu_grant_q;
    assign bus.DmaGrant_H     = dma_grant_q;
    assign bus.RefreshReq_H   = refresh_req_q;
    assign bus.DramStart_H    = start_q;
    assign bus.RefreshPending = pending_q;
    assign bus.Overrun_H      = overrun_q;
    assign bus.Timeout_H      = timeout_q;

endmodule
